// File: rtl/fir_frame_pkg.sv
// Shared types, default widths and the round/saturate helper for the FIR output framer.
package fir_frame_pkg;

  localparam int unsigned InWDefault       = 31;
  localparam int unsigned OutWDefault      = 16;
  localparam int unsigned ShiftDefault     = 15;
  localparam int unsigned FrameLenDefault  = 256;
  localparam int unsigned DepthDefault     = 512;

  // Widest output the helper can produce; callers must keep OUT_W below this.
  localparam int unsigned MaxOutW = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  // Round half-up, arithmetic shift, clamp to out_w bits. Returns {sat, data}.
  // 64-bit arithmetic keeps the add from overflowing for any IN_W below 63.
  function automatic logic [MaxOutW:0] round_sat(input logic signed [63:0] in_val,
                                                  input int unsigned       shift,
                                                  input int unsigned       out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [MaxOutW:0]   res;
    if (shift == 0) begin
      r = in_val;
    end else begin
      r = (in_val + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) begin
      res = {1'b1, hi[MaxOutW-1:0]};
    end else if (r < lo) begin
      res = {1'b1, lo[MaxOutW-1:0]};
    end else begin
      res = {1'b0, r[MaxOutW-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port. Maps to block RAM.
module frame_fifo_mem
  import fir_frame_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault,
  parameter int unsigned WIDTH = OutWDefault
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so the array infers as block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_out_framer.sv
// Scales FIR samples to OUT_W bits, buffers them, and emits fixed-length frames
// over a valid/ready stream.
module fir_out_framer
  import fir_frame_pkg::*;
#(
  parameter int unsigned IN_W      = InWDefault,
  parameter int unsigned OUT_W     = OutWDefault,
  parameter int unsigned SHIFT     = ShiftDefault,
  parameter int unsigned FRAME_LEN = FrameLenDefault,
  parameter int unsigned DEPTH     = DepthDefault
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_last,
  output logic                    overflow,
  output logic                    sat
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned BeatW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [MaxOutW:0]   rs;
  logic               unused_rs;
  logic               stage_valid_q;
  logic [OUT_W-1:0]   stage_data_q;
  logic               sat_q;
  logic               ovf_q;

  logic [AddrW-1:0]   wr_ptr_q;
  logic [AddrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [CntW-1:0]    count_d;
  logic [BeatW-1:0]   beat_q;

  logic               wr_en;
  logic               ovf_set;
  logic               rd_en;
  logic               beat_clr;
  logic               beat_inc;
  logic               beat_last;
  logic [OUT_W-1:0]   rd_data;

  state_t             state_q;
  state_t             state_d;

  assign rs        = round_sat(64'(in_data), SHIFT, OUT_W);
  assign unused_rs = ^rs[MaxOutW-1:OUT_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      sat_q         <= 1'b0;
    end else begin
      stage_valid_q <= in_valid;
      stage_data_q  <= rs[OUT_W-1:0];
      if (in_valid && rs[MaxOutW]) begin
        sat_q <= 1'b1;
      end
    end
  end

  // A full FIFO drops the staged sample; pointers stay put.
  assign wr_en   = stage_valid_q && (count_q != CntW'(DEPTH));
  assign ovf_set = stage_valid_q && (count_q == CntW'(DEPTH));

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q <= count_d;
      if (beat_clr) begin
        beat_q <= '0;
      end else if (beat_inc) begin
        beat_q <= beat_q + BeatW'(1);
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  frame_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (stage_data_q),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign beat_last = (beat_q == BeatW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A whole frame is already buffered when FETCH starts, so SEND cannot underflow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q >= CntW'(FRAME_LEN)) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (m_ready && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // m_data is gated so an asynchronous reset zeroes it without resetting the RAM register.
  always_comb begin
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;
    rd_en    = 1'b0;
    beat_clr = 1'b0;
    beat_inc = 1'b0;
    unique case (state_q)
      IDLE: ;
      FETCH: begin
        rd_en    = 1'b1;
        beat_clr = 1'b1;
      end
      SEND: begin
        m_valid = 1'b1;
        m_last  = beat_last;
        m_data  = rd_data;
        if (m_ready) begin
          beat_inc = 1'b1;
          rd_en    = !beat_last;
        end
      end
      default: ;
    endcase
  end

  assign overflow = ovf_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_fir_out_framer.sv
// Directed bench for fir_out_framer: rounding, saturation, framing, back-pressure,
// overflow and asynchronous reset mid-frame.
module tb_fir_out_framer;

  localparam int unsigned FrameLen = 256;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        in_valid = 1'b0;
  logic [30:0] in_data  = '0;
  logic        m_ready  = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        overflow;
  logic        sat;

  always #5 clk = ~clk;

  fir_out_framer dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .overflow (overflow),
    .sat      (sat)
  );

  int unsigned n_checks    = 0;
  int unsigned n_fail      = 0;
  logic [15:0] exp_q[$];
  int unsigned beat_cnt    = 0;
  int unsigned cyc         = 0;
  int unsigned end_cyc     = 0;
  int unsigned frames_done = 0;
  bit          gap_chk     = 1'b0;
  bit          stalled     = 1'b0;
  logic [15:0] held_data   = '0;
  logic        held_last   = 1'b0;
  logic        obs_valid   = 1'b0;
  logic        obs_sat     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [30:0] enc(input logic [15:0] e);
    return {e, 15'h0};
  endfunction

  // One cycle: sample outputs at negedge, drive inputs, score the beat the next edge takes.
  task automatic step(input logic v, input logic [30:0] d, input logic rdy);
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    obs_valid = m_valid;
    obs_sat   = sat;
    if (stalled) begin
      check("hold_data", 32'(m_data), 32'(held_data));
      check("hold_last", 32'(m_last), 32'(held_last));
    end
    in_valid = v;
    in_data  = d;
    m_ready  = rdy;
    if (m_valid && rdy) begin
      check("beat_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e));
      end
      check("m_last", 32'(m_last), 32'(beat_cnt == FrameLen - 1));
      if (gap_chk && beat_cnt == 0 && frames_done > 0) begin
        check("frame_gap", cyc - end_cyc, 3);
      end
      if (beat_cnt == FrameLen - 1) begin
        end_cyc = cyc;
        frames_done++;
        beat_cnt = 0;
      end else begin
        beat_cnt++;
      end
    end
    stalled   = m_valid && !rdy;
    held_data = m_data;
    held_last = m_last;
  endtask

  task automatic feed(input logic [30:0] d, input logic [15:0] e, input bit push,
                      input logic rdy);
    if (push) exp_q.push_back(e);
    step(1'b1, d, rdy);
  endtask

  task automatic drain(input string tag, input int unsigned left, input bit rnd);
    int unsigned guard = 0;
    while (exp_q.size() > left && guard < 4000) begin
      step(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    check(tag, exp_q.size(), left);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_data"}, 32'(m_data), 0);
    check({tag, "_last"}, 32'(m_last), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_sat"}, 32'(sat), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned f0;
    int unsigned guard;

    // Reset state
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Rounding, frame start latency, ramp order and inter-frame gap
    gap_chk     = 1'b1;
    frames_done = 0;
    for (int i = 0; i < 512; i++) begin
      if (i == 0)      feed(31'h0000_8000, 16'h0001, 1'b1, 1'b1);
      else if (i == 1) feed(31'h7FFF_C000, 16'h0000, 1'b1, 1'b1);
      else             feed(enc(16'(i)), 16'(i), 1'b1, 1'b1);
      if (i >= 256 && i <= 259) check("first_valid", 32'(obs_valid), 32'(i == 259));
    end
    drain("drain_ramp", 0, 1'b0);
    gap_chk = 1'b0;
    check("frames_ramp", frames_done, 2);
    check("sat_after_round", 32'(sat), 0);
    check("ovf_after_ramp", 32'(overflow), 0);

    // Saturation
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      feed(31'h3FFF_FFFF, 16'h7FFF, 1'b1, 1'b1);
      else if (i == 1) feed(31'h4000_0000, 16'h8000, 1'b1, 1'b1);
      else             feed(enc(16'(i * 3)), 16'(i * 3), 1'b1, 1'b1);
      if (i == 0) check("sat_before", 32'(obs_sat), 0);
      if (i == 4) check("sat_sticky", 32'(obs_sat), 1);
    end
    drain("drain_sat", 0, 1'b0);
    check("sat_end", 32'(sat), 1);

    // Back-pressure across three frames
    f0 = frames_done;
    for (int i = 0; i < 768; i++) begin
      feed(enc(16'(i * 1237 + 5)), 16'(i * 1237 + 5), 1'b1, 1'($urandom_range(0, 1)));
      step(1'b0, '0, 1'($urandom_range(0, 1)));
      step(1'b0, '0, 1'($urandom_range(0, 1)));
    end
    drain("drain_bp", 0, 1'b1);
    check("bp_frames", frames_done - f0, 3);
    check("bp_no_ovf", 32'(overflow), 0);

    // Overflow: 513 accepted (one word already in the output register), rest dropped
    f0 = frames_done;
    for (int i = 0; i < 600; i++) begin
      feed(enc(16'(i)), 16'(i), i <= 512, 1'b0);
    end
    repeat (4) step(1'b0, '0, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    check("count_full", 32'(dut.count_q), 512);
    drain("drain_ovf", 1, 1'b0);
    check("ovf_frames", frames_done - f0, 2);
    repeat (4) step(1'b0, '0, 1'b1);
    check("count_left", 32'(dut.count_q), 1);
    check("ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of a frame
    for (int i = 0; i < 255; i++) begin
      feed(enc(16'(1000 + i)), 16'(1000 + i), 1'b1, 1'b1);
    end
    guard = 0;
    while (beat_cnt != 100 && guard < 1000) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    check("reached_beat100", beat_cnt, 100);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    beat_cnt = 0;
    stalled  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      feed(enc(16'(2000 + i)), 16'(2000 + i), 1'b1, 1'b1);
      if (i == 255) check("no_early_frame", 32'(obs_valid), 0);
    end
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, '0, 1'b1);
      check("restart_valid", 32'(obs_valid), 32'(j == 4));
    end
    drain("drain_rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_framer.md
# fir_out_framer

Consumes the FIR filter's output stream (`valid`/`yout`) and rounds and saturates each sample from 31 to 16 bits. Samples are buffered in a circular FIFO and released as fixed-length frames over a valid/ready stream to the FFT and display path. The block sits between the FIR core and the FFT input. It decouples the FIR's free-running sample strobe from the frame-oriented, back-pressured FFT interface.

## Interface
- `IN_W`, 31: FIR output width, two's complement.
- `OUT_W`, 16: output sample width, two's complement.
- `SHIFT`, 15: right shift applied after rounding.
- `FRAME_LEN`, 256: samples per frame; must be ≤ `DEPTH`.
- `DEPTH`, 512: FIFO depth; power of 2.

- `clk` in 1: single clock; all logic on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: FIR `valid`; one sample per high cycle.
- `in_data` in `IN_W`: FIR `yout`, signed.
- `m_valid` out 1: output sample valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `OUT_W`: scaled sample, signed.
- `m_last` out 1: high on the final beat of a frame.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `sat` out 1: sticky; at least one sample was saturated.

## Operation
- **Scaling:** r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits.
  - If r > 2^(OUT_W-1)-1, output 0x7FFF and set `sat`.
  - If r < -2^(OUT_W-1), output 0x8000 and set `sat`.
- **Stage register:** holds the scaled sample and a stage-valid bit. It is loaded on every edge.
- **FIFO write:** a stage-valid sample is written on the next edge.
  - If `count == DEPTH`, the write is dropped, `overflow` is set, and the pointers are unchanged.
- **FIFO storage:** `DEPTH`×`OUT_W` memory with registered read. Write and read pointers are log2(DEPTH) bits wide and wrap naturally. `count` is log2(DEPTH)+1 bits wide.
- **FSM states:** IDLE, FETCH, SEND.
  - **IDLE:** `m_valid` = 0. Go to FETCH when `count >= FRAME_LEN`.
  - **FETCH:** issue the read of the first word, decrement `count`, clear `beat` to 0, then go to SEND.
  - **SEND:** `m_valid` = 1. `m_last` = (`beat == FRAME_LEN-1`). On each handshake (`m_valid & m_ready`):
    - `beat` increments.
    - If it was not the last beat, the next word is read into the output register in the same edge and `count` decrements.
    - On the last beat, go to IDLE.
- **Stall:** while `m_ready` is low in SEND, `m_data` and `m_last` are held stable.
- **Simultaneous write and read:** `count` is unchanged.
- **Capacity:** a frame is reserved at FETCH, so SEND never underflows.
- **Sticky flags:** `overflow` and `sat` clear only on reset.

## Timing
- **Reset values:** `m_valid` = 0, `m_data` = 0, `m_last` = 0, `overflow` = 0, `sat` = 0. FSM = IDLE, pointers = 0, `count` = 0, `beat` = 0.
- **Write latency:** a sample sampled at edge k is in the stage register after k and written to memory at k+1. `count` reflects it after k+1.
- **Frame start:** `count` reaches `FRAME_LEN` after edge n. Edge n+1 moves the FSM to FETCH, and edge n+2 enters SEND with `m_valid` = 1. The first beat is available 2 cycles after the threshold is reached.
- **Throughput:** with `m_ready` held high, a frame is `FRAME_LEN` consecutive beats. There are then at least 2 idle cycles (IDLE, FETCH) before the next frame.
- **Input side:** never back-pressured. The input accepts 1 sample/cycle in all states.
- **Reset mid-frame:** the frame is aborted with no `m_last`, and all buffered data is discarded.

## Structure
- Package `fir_frame_pkg`:
  - `state_t` enum {IDLE, FETCH, SEND}
  - default widths as localparams
  - the function `round_sat(in, shift)` returning {sat, data}
- Sub-module `frame_fifo_mem`: simple dual-port RAM with one write port and a registered read port, `DEPTH`×`OUT_W`, synthesizable to block RAM.
- Top-level: scaling stage, pointers, `count`, FSM, output register.

## Test plan
- **Rounding:** `in_data` = 0x0000_8000 → `m_data` = 0x0001. `in_data` = 0x7FFF_C000 (-16384) → 0x0000. `sat` stays 0.
- **Saturation:**
  - 0x3FFF_FFFF → 0x7FFF with `sat` = 1.
  - 0x4000_0000 (-2^30) → 0x8000.
  - Check `sat` is still 1 after a following in-range sample.
- **Frame formation:**
  - Input: ramp 0..255×32768 with `in_valid` every cycle and `m_ready` = 1.
  - Expected: first `m_valid` 2 cycles after the 256th write; `m_data` 0..255 in order; `m_last` only on beat 255; then 2 IDLE/FETCH cycles.
- **Back-pressure:**
  - Input: toggle `m_ready` randomly during SEND.
  - Expected: `m_data`/`m_last` held while stalled; sequence gap-free and duplicate-free across 3 frames.
- **Overflow:**
  - Input: 600 samples with `m_ready` = 0.
  - Expected: `count` saturates at 512 and `overflow` = 1. The first frame delivered is samples 0..255 and the FIFO pointers stay consistent.
- **Reset mid-frame:**
  - Input: assert `rstn` = 0 at beat 100.
  - Expected: all outputs 0 immediately (asynchronous). After release, the next frame starts only after 256 new samples.
